// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the RV32I datapath (slave).
interface multicycle_controller_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         ImmSrc;
    logic               Illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, state
    );
    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a shared-ALU/shared-memory RV32I datapath (lw, sw, R, I, beq, jal).
// Optional MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until mem_ready.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECR    = STATE_W'(6),
        ALUWB    = STATE_W'(7),
        EXECI    = STATE_W'(8),
        JAL      = STATE_W'(9),
        BEQ      = STATE_W'(10)
    } state_e;

    state_e     state_q, state_d;
    logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] res_src, alu_a, alu_b, alu_op, imm_src;
    logic       mem_go;

`ifdef MEM_WAIT_EN
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_go           = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        adr_src   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        res_src   = 2'b00;
        alu_a     = 2'b00;
        alu_b     = 2'b00;
        alu_op    = 2'b00;
        case (state_q)
            FETCH: begin
                res_src = 2'b10;
                alu_b   = 2'b10;
                if (mem_go) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                // Branch target is precomputed here into ALUOut for BEQ
                alu_a = 2'b01;
                alu_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_a   = 2'b10;
                alu_b   = 2'b01;
                state_d = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (mem_go) state_d = MEMWB;
            end
            MEMWB: begin
                res_src   = 2'b01;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_go) state_d = FETCH;
            end
            EXECR: begin
                alu_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                alu_a   = 2'b10;
                alu_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = ALUWB;
            end
            JAL: begin
                alu_a     = 2'b01;
                alu_b     = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_a   = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Mux selects already show FETCH values during reset; only the enables need gating
    assign bus.PCWrite   = ~rst & (pc_update | (branch & bus.zero));
    assign bus.MemWrite  = ~rst & mem_write;
    assign bus.IRWrite   = ~rst & ir_write;
    assign bus.RegWrite  = ~rst & reg_write;
    assign bus.Illegal   = ~rst & illegal;
    assign bus.AdrSrc    = adr_src;
    assign bus.ResultSrc = res_src;
    assign bus.ALUSrcA   = alu_a;
    assign bus.ALUSrcB   = alu_b;
    assign bus.ALUOp     = alu_op;
    assign bus.ImmSrc    = imm_src;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller against a per-opcode state-sequence model.
module tb_multicycle_controller;
    localparam int STATE_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_controller_if #(.STATE_W(STATE_W)) bus ();
    multicycle_controller #(.STATE_W(STATE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int seq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Expected visit order of one instruction, FETCH through its last state
    function automatic void build_seq(input logic [6:0] o);
        case (o)
            7'b0000011: seq = '{0, 1, 2, 3, 4};
            7'b0100011: seq = '{0, 1, 2, 5};
            7'b0110011: seq = '{0, 1, 6, 7};
            7'b0010011: seq = '{0, 1, 8, 7};
            7'b1101111: seq = '{0, 1, 9, 7};
            7'b1100011: seq = '{0, 1, 10};
            default:    seq = '{0, 1};
        endcase
    endfunction

    // Packed {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Illegal}
    function automatic logic [13:0] ref_out(input int s, input logic z, input logic rdy, input logic [6:0] o);
        logic pcu, br, adr, mw, irw, rw, ill;
        logic [1:0] res, a, b, aop;
        {pcu, br, adr, mw, irw, rw, ill} = '0;
        {res, a, b, aop} = '0;
        case (s)
            0:  begin pcu = rdy; irw = rdy; res = 2'b10; b = 2'b10; end
            1:  begin a = 2'b01; b = 2'b01; ill = !is_legal(o); end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1'b1;
            4:  begin res = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  rw = 1'b1;
            8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            9:  begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
            10: begin a = 2'b10; aop = 2'b01; br = 1'b1; end
            default: ;
        endcase
        return {pcu | (br & z), adr, mw, irw, rw, res, a, b, aop, ill};
    endfunction

    function automatic logic [13:0] dut_out();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.Illegal};
    endfunction

    // zmode: 0/1 fixed zero flag, 2 random; rst_mw pulses reset on the first MEMWRITE cycle
    task automatic run_instr(input logic [6:0] o, input int zmode, input bit rst_mw);
        int  i = 0;
        int  guard = 0;
        int  s;
        bit  rdy, hold;
        build_seq(o);
        while (i < seq.size()) begin
            s = seq[i];
            bus.op   = (s == 1 || s == 2) ? o : 7'($urandom);
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
`ifdef MEM_WAIT_EN
            rdy  = ($urandom_range(0, 2) != 0);
            hold = (s == 0 || s == 3 || s == 5) && !rdy;
`else
            rdy  = 1'($urandom_range(0, 1));
            hold = 1'b0;
`endif
            bus.mem_ready = rdy;
            @(negedge clk);
            check("state", 32'(bus.state), 32'(s));
            check("ctl", 32'(dut_out()), 32'(ref_out(s, bus.zero, !hold, bus.op)));
            check("imm", 32'(bus.ImmSrc), 32'(imm_ref(bus.op)));
            if (rst_mw && s == 5) begin
                rst = 1'b1;
                #1;
                check("rst_state", 32'(bus.state), 32'd0);
                check("rst_ctl", 32'(dut_out()), 32'(ref_out(0, bus.zero, 1'b0, bus.op)));
                @(posedge clk);
                #1;
                check("rst_hold", 32'(bus.state), 32'd0);
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (!hold) i++;
            guard++;
            if (guard > 200) begin
                check("stall_bound", 32'(guard), 32'd200);
                return;
            end
        end
    endtask

    initial begin
        logic [6:0] ops [8];
        logic [6:0] o;
        int k;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
        rst = 1'b1;
        bus.op = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(bus.state), 32'd0);
        check("reset_ctl", 32'(dut_out()), 32'(ref_out(0, 1'b0, 1'b0, bus.op)));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(7'b0000011, 2, 1'b0);
        run_instr(7'b0100011, 2, 1'b0);
        run_instr(7'b1100011, 1, 1'b0);
        run_instr(7'b1100011, 0, 1'b0);
        run_instr(7'b0110011, 2, 1'b0);
        run_instr(7'b0010011, 2, 1'b0);
        run_instr(7'b1101111, 2, 1'b0);
        run_instr(7'b1111111, 2, 1'b0);
        run_instr(7'b0100011, 2, 1'b1);
        run_instr(7'b0000011, 2, 1'b0);

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 7);
            o = (k == 7) ? 7'($urandom) : ops[k];
            run_instr(o, 2, (o == 7'b0100011) && ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
